// File: rtl/add_seq_wide_if.sv
// Operand/result bus of the nibble-serial wide adder.
// The master supplies operands and start. The slave returns busy/done and the held result.
interface add_seq_wide_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         co;

    modport master (
        output start, a, b, ci,
        input  busy, done, s, co
    );

    modport slave (
        input  start, a, b, ci,
        output busy, done, s, co
    );
endinterface

// File: rtl/add_seq_wide.sv
// Nibble-serial wide adder sequencer.
// Drives one external 4-bit adder stage one nibble per clock and registers the carry
// between nibbles, so a 4*NIBBLES-bit add takes NIBBLES cycles plus one DONE cycle.
module add_seq_wide #(
    parameter int NIBBLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    add_seq_wide_if.slave       bus,
    output logic [3:0]          add_a,
    output logic [3:0]          add_b,
    output logic                add_ci,
    input  logic [3:0]          add_s,
    input  logic                add_co
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     s_q, s_d;
    logic             carry_q, carry_d;
    logic             co_q, co_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // Present the current operand nibbles and running carry to the adder stage, only in RUN.
    always_comb begin
        add_a  = 4'h0;
        add_b  = 4'h0;
        add_ci = 1'b0;
        if (state_q == RUN) begin
            add_ci = carry_q;
            for (int n = 0; n < NIBBLES; n++) begin
                if (idx_q == IDX_W'(n)) begin
                    add_a = a_q[4*n +: 4];
                    add_b = b_q[4*n +: 4];
                end
            end
        end
    end

    // Next-state logic: accept start in IDLE/DONE, step one nibble per cycle in RUN.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        co_d    = co_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.ci;
                    idx_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                for (int n = 0; n < NIBBLES; n++) begin
                    if (idx_q == IDX_W'(n)) begin
                        s_d[4*n +: 4] = add_s;
                    end
                end
                carry_d = add_co;
                if (idx_q == LAST_IDX) begin
                    co_d    = add_co;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; asynchronous reset aborts any add in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.s    = s_q;
    assign bus.co   = co_q;
endmodule

// File: tb/tb_add_seq_wide.sv
// Testbench for add_seq_wide with NIBBLES=4 and a behavioural 4-bit adder stage.
module tb_add_seq_wide;
    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] add_a, add_b, add_s;
    logic       add_ci, add_co;

    int checks   = 0;
    int failures = 0;

    add_seq_wide_if #(.NIBBLES(NIBBLES)) bus ();

    add_seq_wide #(.NIBBLES(NIBBLES)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .add_a  (add_a),
        .add_b  (add_b),
        .add_ci (add_ci),
        .add_s  (add_s),
        .add_co (add_co)
    );

    // The external add4 stage.
    assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_ci};

    always #5 clk = ~clk;

    function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic ci);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    endfunction

    // One complete add: start at one edge, check busy/done/adder drive every cycle, then result.
    task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input string name);
        logic [W:0] exp;
        bit         tim_ok;
        exp    = ref_sum(a, b, ci);
        tim_ok = 1'b1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.ci    = ci;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = ~b;
        bus.ci    = ~ci;
        for (int k = 0; k < NIBBLES; k++) begin
            if (k > 0) @(negedge clk);
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) tim_ok = 1'b0;
            if (add_a !== a[4*k +: 4] || add_b !== b[4*k +: 4]) tim_ok = 1'b0;
            if (k == 0 && add_ci !== ci) tim_ok = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (!tim_ok) begin
            failures++;
            $display("FAIL %s_run_timing: busy/done/add drive wrong during RUN (a=%h b=%h ci=%0d)",
                     name, a, b, ci);
        end
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || add_a !== 4'h0 || add_ci !== 1'b0) begin
            failures++;
            $display("FAIL %s_done: done=%b busy=%b add_a=%h, required done=1 busy=0 add_a=0",
                     name, bus.done, bus.busy, add_a);
        end
        checks++;
        if ({bus.co, bus.s} !== exp) begin
            failures++;
            $display("FAIL %s_sum: got co=%b s=%h, required co=%b s=%h",
                     name, bus.co, bus.s, exp[W], exp[W-1:0]);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.ci    = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.s !== '0 || bus.co !== 1'b0 ||
            add_a !== 4'h0 || add_b !== 4'h0 || add_ci !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b s=%h co=%b add_a=%h add_b=%h add_ci=%b, required all 0",
                     bus.busy, bus.done, bus.s, bus.co, add_a, add_b, add_ci);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_directed();
        do_add(16'h1234, 16'h4321, 1'b0, "basic");
        do_add(16'hFFFF, 16'h0001, 1'b0, "carry_chain");
        do_add(16'hFFFF, 16'h0000, 1'b1, "carry_in_chain");
        do_add(16'h8000, 16'h8000, 1'b0, "top_carry");
        do_add(16'h0000, 16'h0000, 1'b0, "zero");
    endtask

    task automatic test_back_to_back();
        logic [W:0] exp1, exp2;
        bit         ok;
        exp1 = ref_sum(16'hA5A5, 16'h0F0F, 1'b1);
        exp2 = ref_sum(16'h7777, 16'h1119, 1'b0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'hA5A5;
        bus.b     = 16'h0F0F;
        bus.ci    = 1'b1;
        @(negedge clk);
        // start stays high with other operands throughout RUN
        bus.a  = 16'h3C3C;
        bus.b  = 16'hC3C3;
        bus.ci = 1'b0;
        ok = 1'b1;
        for (int k = 0; k < NIBBLES; k++) begin
            if (k > 0) @(negedge clk);
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) ok = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (!ok || bus.done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first_timing: done=%b busy=%b (run ok=%0d), required done=1",
                     bus.done, bus.busy, ok);
        end
        checks++;
        if ({bus.co, bus.s} !== exp1) begin
            failures++;
            $display("FAIL b2b_first_sum: got %h, required %h", {bus.co, bus.s}, exp1);
        end
        // DONE cycle: new operands with start high must be accepted at the next edge
        bus.a  = 16'h7777;
        bus.b  = 16'h1119;
        bus.ci = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_no_gap: busy=%b done=%b, required busy=1 done=0", bus.busy, bus.done);
        end
        repeat (NIBBLES) @(negedge clk);
        checks++;
        if (bus.done !== 1'b1 || {bus.co, bus.s} !== exp2) begin
            failures++;
            $display("FAIL b2b_second: done=%b got %h, required done=1 %h",
                     bus.done, {bus.co, bus.s}, exp2);
        end
    endtask

    task automatic test_abort();
        bit saw_done;
        do_add(16'h1234, 16'h4321, 1'b0, "pre_abort");
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'hDEAD;
        bus.b     = 16'hBEEF;
        bus.ci    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.s !== '0 || bus.co !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            add_a !== 4'h0) begin
            failures++;
            $display("FAIL abort_reset: s=%h co=%b busy=%b done=%b add_a=%h, required all 0",
                     bus.s, bus.co, bus.busy, bus.done, add_a);
        end
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        saw_done = 1'b0;
        repeat (NIBBLES + 2) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            failures++;
            $display("FAIL abort_no_done: done/busy asserted after aborted add, required 0");
        end
        do_add(16'h0FF0, 16'h0F10, 1'b1, "post_abort");
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        logic         ci;
        for (int i = 0; i < 1000; i++) begin
            a  = W'($urandom);
            b  = W'($urandom);
            ci = 1'($urandom);
            do_add(a, b, ci, "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
